bp_dma_to_mig_app: RTL

- Single-clock adapter that sits directly downstream of the unicore's bsg_cache DMA port and directly upstream of the MIG DDR3 native app (UI) interface, inside the DRAM controller's UI clock domain.
- Each DMA packet is one cache-block read or write. The block converts it into block_width_p/app_data_width_p MIG app commands.
- It repacks dma_data_width_p-wide DMA beats into app_data_width_p-wide MIG words, and buffers one full block of read data because the MIG read return cannot be back-pressured.

---
 rtl/bp_dma_to_mig_app.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/bp_dma_to_mig_app.sv
// bsg_cache DMA to MIG DDR3 native app adapter.
// Splits a cache-block packet into app-width MIG commands and repacks data.
module bp_dma_to_mig_app #(
  parameter int addr_width_p     = 28,
  parameter int dma_data_width_p = 64,
  parameter int block_width_p    = 512,
  parameter int app_data_width_p = 128,
  parameter int app_addr_width_p = 28,
  parameter int dq_width_p       = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          init_calib_complete_i,
  input  logic [addr_width_p:0]         dma_pkt_i,
  input  logic                          dma_pkt_v_i,
  output logic                          dma_pkt_yumi_o,
  output logic [dma_data_width_p-1:0]   dma_data_o,
  output logic                          dma_data_v_o,
  input  logic                          dma_data_ready_and_i,
  input  logic [dma_data_width_p-1:0]   dma_data_i,
  input  logic                          dma_data_v_i,
  output logic                          dma_data_yumi_o,
  output logic [app_addr_width_p-1:0]   app_addr_o,
  output logic [2:0]                    app_cmd_o,
  output logic                          app_en_o,
  input  logic                          app_rdy_i,
  output logic [app_data_width_p-1:0]   app_wdf_data_o,
  output logic [app_data_width_p/8-1:0] app_wdf_mask_o,
  output logic                          app_wdf_wren_o,
  output logic                          app_wdf_end_o,
  input  logic                          app_wdf_rdy_i,
  input  logic [app_data_width_p-1:0]   app_rd_data_i,
  input  logic                          app_rd_data_valid_i,
  input  logic                          app_rd_data_end_i
);

  localparam int R = app_data_width_p / dma_data_width_p;
  localparam int N = block_width_p / app_data_width_p;
  localparam int B = block_width_p / dma_data_width_p;
  localparam int S = app_data_width_p / dq_width_p;
  localparam int blk_off_lp = $clog2(block_width_p / 8);
  localparam int dq_sh_lp = $clog2(dq_width_p / 8);
  localparam int nw_lp = $clog2(N + 1);
  localparam int bw_lp = $clog2(B + 1);
  localparam int rw_lp = $clog2(R + 1);
  localparam logic [nw_lp-1:0] n_lp = nw_lp'(N);
  localparam logic [bw_lp-1:0] b_last_lp = bw_lp'(B - 1);
  localparam logic [rw_lp-1:0] r_last_lp = rw_lp'(R - 1);

  typedef enum logic [2:0] {
    e_calib, e_ready, e_rd_cmd, e_rd_wait,
    e_rd_send, e_wr_fill, e_wr_issue
  } state_e;

  state_e                    state_q, state_d;
  logic [addr_width_p-1:0]   base_q, base_d;
  logic [nw_lp-1:0]          cmd_cnt_q, cmd_cnt_d;
  logic [nw_lp-1:0]          rd_cnt_q, rd_cnt_d;
  logic [nw_lp-1:0]          word_cnt_q, word_cnt_d;
  logic [bw_lp-1:0]          beat_q, beat_d;
  logic [rw_lp-1:0]          wbeat_q, wbeat_d;
  logic                      cmd_done_q, cmd_done_d;
  logic                      data_done_q, data_done_d;
  logic [block_width_p-1:0]  buf_q, buf_d;
  logic [app_data_width_p-1:0] wdata_q, wdata_d;
  logic [nw_lp-1:0]          word_idx;
  logic                      rd_capture;
  logic                      unused;

  assign unused = ^{app_rd_data_end_i, dma_pkt_i[blk_off_lp-1:0]};

  assign word_idx = (state_q == e_wr_issue) ? word_cnt_q : cmd_cnt_q;
  assign app_addr_o = app_addr_width_p'(base_q >> dq_sh_lp)
                    + app_addr_width_p'(word_idx) * app_addr_width_p'(S);
  assign app_cmd_o = (state_q == e_wr_issue) ? 3'b000 : 3'b001;
  assign app_en_o = (state_q == e_rd_cmd)
                  | ((state_q == e_wr_issue) & ~cmd_done_q);
  assign app_wdf_wren_o = (state_q == e_wr_issue) & ~data_done_q;
  assign app_wdf_end_o = app_wdf_wren_o;
  assign app_wdf_mask_o = '0;
  assign app_wdf_data_o = wdata_q;
  assign dma_pkt_yumi_o = (state_q == e_ready) & dma_pkt_v_i;
  assign dma_data_yumi_o = (state_q == e_wr_fill) & dma_data_v_i;
  assign dma_data_v_o = (state_q == e_rd_send);
  assign dma_data_o = buf_q[beat_q*dma_data_width_p +: dma_data_width_p];

  // MIG read return has no back-pressure, so capture whenever a read is open
  assign rd_capture = app_rd_data_valid_i & (rd_cnt_q < n_lp)
                    & ((state_q == e_rd_cmd) | (state_q == e_rd_wait));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cmd_cnt_d   = cmd_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    word_cnt_d  = word_cnt_q;
    beat_d      = beat_q;
    wbeat_d     = wbeat_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    buf_d       = buf_q;
    wdata_d     = wdata_q;
    if (rd_capture) begin
      buf_d[rd_cnt_q*app_data_width_p +: app_data_width_p] = app_rd_data_i;
      rd_cnt_d = rd_cnt_q + nw_lp'(1);
    end
    unique case (state_q)
      e_calib: begin
        if (init_calib_complete_i) state_d = e_ready;
      end
      e_ready: begin
        if (dma_pkt_v_i) begin
          base_d = {dma_pkt_i[addr_width_p-1:blk_off_lp],
                    {blk_off_lp{1'b0}}};
          cmd_cnt_d   = '0;
          rd_cnt_d    = '0;
          word_cnt_d  = '0;
          beat_d      = '0;
          wbeat_d     = '0;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          state_d = dma_pkt_i[addr_width_p] ? e_wr_fill : e_rd_cmd;
        end
      end
      e_rd_cmd: begin
        if (app_rdy_i) cmd_cnt_d = cmd_cnt_q + nw_lp'(1);
        if (rd_cnt_d == n_lp) state_d = e_rd_send;
        else if (cmd_cnt_d == n_lp) state_d = e_rd_wait;
      end
      e_rd_wait: begin
        if (rd_cnt_d == n_lp) state_d = e_rd_send;
      end
      e_rd_send: begin
        if (dma_data_ready_and_i) begin
          if (beat_q == b_last_lp) begin
            beat_d  = '0;
            state_d = e_ready;
          end else begin
            beat_d = beat_q + bw_lp'(1);
          end
        end
      end
      e_wr_fill: begin
        if (dma_data_v_i) begin
          wdata_d[wbeat_q*dma_data_width_p +: dma_data_width_p] = dma_data_i;
          if (wbeat_q == r_last_lp) begin
            wbeat_d = '0;
            state_d = e_wr_issue;
          end else begin
            wbeat_d = wbeat_q + rw_lp'(1);
          end
        end
      end
      e_wr_issue: begin
        cmd_done_d  = cmd_done_q | app_rdy_i;
        data_done_d = data_done_q | app_wdf_rdy_i;
        if (cmd_done_d & data_done_d) begin
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          word_cnt_d  = word_cnt_q + nw_lp'(1);
          state_d = (word_cnt_d == n_lp) ? e_ready : e_wr_fill;
        end
      end
      default: state_d = e_calib;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_calib;
      base_q      <= '0;
      cmd_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      word_cnt_q  <= '0;
      beat_q      <= '0;
      wbeat_q     <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cmd_cnt_q   <= cmd_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      word_cnt_q  <= word_cnt_d;
      beat_q      <= beat_d;
      wbeat_q     <= wbeat_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_q   <= buf_d;
    wdata_q <= wdata_d;
  end

endmodule
